// File: rtl/amo_sequencer_if.sv
// rtl/amo_sequencer_if.sv - single-port memory bus between the AMO sequencer and memory
//
// Signals:
//   mem_req    sequencer -> memory  request, held until mem_ready
//   mem_we     sequencer -> memory  1 = write, 0 = read (valid with mem_req)
//   mem_addr   sequencer -> memory  word-aligned address (0 when idle)
//   mem_wdata  sequencer -> memory  write data (0 when not writing)
//   mem_rdata  memory -> sequencer  read data, valid on a read handshake
//   mem_ready  memory -> sequencer  accept/complete for the current request
`timescale 1ns/1ps
interface amo_sequencer_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/amo_sequencer.sv
// rtl/amo_sequencer.sv - multi-cycle RV32A atomic memory operation controller
//
// Read-modify-write of one memory word: read mem[addr], run the old value and
// rs2 through the external ALU, write the result back, return the old value.
//
// Optional feature macro: AMO_LRSC_EN (adds LR/SC with a one-entry reservation).
//
// Parameters:
//   MEM_TIMEOUT  cycles a memory request may wait for mem_ready (1..255)
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start_i           one-cycle request, sampled only in IDLE
//   funct5_i          AMO type
//   addr_i, rs2_i     rs1 (byte address) and rs2 values
//   busy_o            operation in flight (RD/EXEC/WR)
//   done_o            one-cycle completion pulse
//   err_o             with done: illegal funct5, misaligned address or timeout
//   rd_data_o         with done: old memory value (SC: 0 ok / 1 fail), 0 on error
//   alu_a_o/alu_b_o   ALU operands, 0 outside EXEC
//   alu_op_o          ALU opcode, 0 outside EXEC
//   alu_out_i         combinational ALU result
//   mem               memory bus (master side)
`timescale 1ns/1ps

// ALU opcode encoding; an existing definitions file takes precedence.
`ifndef ALU_ADD
`define ALU_ADD  4'd1
`define ALU_SWAP 4'd2
`define ALU_XOR  4'd3
`define ALU_OR   4'd4
`define ALU_AND  4'd5
`define ALU_MIN  4'd6
`define ALU_MAX  4'd7
`endif

module amo_sequencer #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic [4:0]             funct5_i,
    input  logic [31:0]            addr_i,
    input  logic [31:0]            rs2_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o,
    output logic [31:0]            rd_data_o,
    output logic [31:0]            alu_a_o,
    output logic [31:0]            alu_b_o,
    output logic [3:0]             alu_op_o,
    input  logic [31:0]            alu_out_i,
    amo_sequencer_if.master        mem
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_EXEC = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [4:0] F_ADD  = 5'b00000;
    localparam logic [4:0] F_SWAP = 5'b00001;
    localparam logic [4:0] F_LR   = 5'b00010;
    localparam logic [4:0] F_SC   = 5'b00011;
    localparam logic [4:0] F_XOR  = 5'b00100;
    localparam logic [4:0] F_OR   = 5'b01000;
    localparam logic [4:0] F_AND  = 5'b01100;
    localparam logic [4:0] F_MIN  = 5'b10000;
    localparam logic [4:0] F_MAX  = 5'b10100;
    localparam logic [4:0] F_MINU = 5'b11000;
    localparam logic [4:0] F_MAXU = 5'b11100;

    // Last count value before giving up; the request has then been up MEM_TIMEOUT cycles.
    localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

    logic [2:0]  state_q, state_d;
    logic [4:0]  funct5_q, funct5_d;
    logic [29:0] addr_q, addr_d;
    logic [31:0] rs2_q, rs2_d;
    logic [31:0] old_q, old_d;
    logic [31:0] new_q, new_d;
    logic        err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;

`ifdef AMO_LRSC_EN
    logic        resv_valid_q, resv_valid_d;
    logic [29:0] resv_addr_q, resv_addr_d;
`endif

    function automatic logic is_legal(input logic [4:0] f);
        case (f)
            F_ADD, F_SWAP, F_XOR, F_OR, F_AND,
            F_MIN, F_MAX, F_MINU, F_MAXU: is_legal = 1'b1;
`ifdef AMO_LRSC_EN
            F_LR, F_SC:                   is_legal = 1'b1;
`endif
            default:                      is_legal = 1'b0;
        endcase
    endfunction

    // Signed MIN/MAX reuse the unsigned ALU comparator: flipping the sign bit
    // maps two's-complement order onto unsigned order and back.
    logic        is_signed;
    logic [31:0] sign_flip;
    logic        in_exec;

    assign is_signed = (funct5_q == F_MIN) || (funct5_q == F_MAX);
    assign sign_flip = {is_signed, 31'd0};
    assign in_exec   = (state_q == S_EXEC);

    always_comb begin
        state_d  = state_q;
        funct5_d = funct5_q;
        addr_d   = addr_q;
        rs2_d    = rs2_q;
        old_d    = old_q;
        new_d    = new_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
`ifdef AMO_LRSC_EN
        resv_valid_d = resv_valid_q;
        resv_addr_d  = resv_addr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    funct5_d = funct5_i;
                    addr_d   = addr_i[31:2];
                    rs2_d    = rs2_i;
                    old_d    = 32'd0;
                    new_d    = 32'd0;
                    err_d    = 1'b0;
                    cnt_d    = 8'd0;
                    if (!is_legal(funct5_i) || (addr_i[1:0] != 2'b00)) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
`ifdef AMO_LRSC_EN
                    else if (funct5_i == F_SC) begin
                        // SC resolves against the reservation without a read.
                        resv_valid_d = 1'b0;
                        if (resv_valid_q && (resv_addr_q == addr_i[31:2])) begin
                            new_d   = rs2_i;
                            state_d = S_WR;
                        end else begin
                            old_d   = 32'd1;
                            state_d = S_DONE;
                        end
                    end
`endif
                    else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                if (mem.mem_ready) begin
                    old_d   = mem.mem_rdata;
                    state_d = S_EXEC;
`ifdef AMO_LRSC_EN
                    if (funct5_q == F_LR) begin
                        resv_valid_d = 1'b1;
                        resv_addr_d  = addr_q;
                        state_d      = S_DONE;
                    end
`endif
                end else if (cnt_q == TO_LAST) begin
                    old_d   = 32'd0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_EXEC: begin
                new_d   = alu_out_i ^ sign_flip;
                cnt_d   = 8'd0;
                state_d = S_WR;
            end
            S_WR: begin
                if (mem.mem_ready) begin
                    state_d = S_DONE;
`ifdef AMO_LRSC_EN
                    if (resv_addr_q == addr_q) begin
                        resv_valid_d = 1'b0;
                    end
`endif
                end else if (cnt_q == TO_LAST) begin
                    old_d   = 32'd0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            funct5_q <= 5'd0;
            addr_q   <= 30'd0;
            rs2_q    <= 32'd0;
            old_q    <= 32'd0;
            new_q    <= 32'd0;
            err_q    <= 1'b0;
            cnt_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            funct5_q <= funct5_d;
            addr_q   <= addr_d;
            rs2_q    <= rs2_d;
            old_q    <= old_d;
            new_q    <= new_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef AMO_LRSC_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resv_valid_q <= 1'b0;
            resv_addr_q  <= 30'd0;
        end else begin
            resv_valid_q <= resv_valid_d;
            resv_addr_q  <= resv_addr_d;
        end
    end
`endif

    // Outputs decode straight from state so an asynchronous reset drops the bus at once.
    assign mem.mem_req   = (state_q == S_RD) || (state_q == S_WR);
    assign mem.mem_we    = (state_q == S_WR);
    assign mem.mem_addr  = mem.mem_req ? {addr_q, 2'b00} : 32'd0;
    assign mem.mem_wdata = (state_q == S_WR) ? new_q : 32'd0;

    assign busy_o    = (state_q == S_RD) || (state_q == S_EXEC) || (state_q == S_WR);
    assign done_o    = (state_q == S_DONE);
    assign err_o     = done_o && err_q;
    assign rd_data_o = (done_o && !err_q) ? old_q : 32'd0;

    assign alu_a_o = in_exec ? (old_q ^ sign_flip) : 32'd0;
    assign alu_b_o = in_exec ? (rs2_q ^ sign_flip) : 32'd0;

    always_comb begin
        alu_op_o = 4'd0;
        if (in_exec) begin
            case (funct5_q)
                F_ADD:         alu_op_o = `ALU_ADD;
                F_SWAP:        alu_op_o = `ALU_SWAP;
                F_XOR:         alu_op_o = `ALU_XOR;
                F_OR:          alu_op_o = `ALU_OR;
                F_AND:         alu_op_o = `ALU_AND;
                F_MIN, F_MINU: alu_op_o = `ALU_MIN;
                F_MAX, F_MAXU: alu_op_o = `ALU_MAX;
                default:       alu_op_o = 4'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_amo_sequencer.sv
// tb/tb_amo_sequencer.sv - self-checking bench for amo_sequencer
`timescale 1ns/1ps

`ifndef ALU_ADD
`define ALU_ADD  4'd1
`define ALU_SWAP 4'd2
`define ALU_XOR  4'd3
`define ALU_OR   4'd4
`define ALU_AND  4'd5
`define ALU_MIN  4'd6
`define ALU_MAX  4'd7
`endif

module tb_amo_sequencer;
    localparam int TO = 255;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  funct5 = 5'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] rs2 = 32'd0;
    logic        busy_o, done_o, err_o;
    logic [31:0] rd_data_o, alu_a_o, alu_b_o, alu_out;
    logic [3:0]  alu_op_o;

    always #5 clk = ~clk;

    amo_sequencer_if m();

    amo_sequencer #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .funct5_i(funct5),
        .addr_i(addr), .rs2_i(rs2), .busy_o(busy_o), .done_o(done_o),
        .err_o(err_o), .rd_data_o(rd_data_o), .alu_a_o(alu_a_o),
        .alu_b_o(alu_b_o), .alu_op_o(alu_op_o), .alu_out_i(alu_out), .mem(m)
    );

    // Unsigned ALU environment model
    always_comb begin
        alu_out = 32'd0;
        case (alu_op_o)
            `ALU_ADD:  alu_out = alu_a_o + alu_b_o;
            `ALU_SWAP: alu_out = alu_b_o;
            `ALU_XOR:  alu_out = alu_a_o ^ alu_b_o;
            `ALU_OR:   alu_out = alu_a_o | alu_b_o;
            `ALU_AND:  alu_out = alu_a_o & alu_b_o;
            `ALU_MIN:  alu_out = (alu_a_o < alu_b_o) ? alu_a_o : alu_b_o;
            `ALU_MAX:  alu_out = (alu_a_o > alu_b_o) ? alu_a_o : alu_b_o;
            default:   alu_out = 32'd0;
        endcase
    end

    // Memory responder: ready after rd_wait / wr_wait stalled cycles
    logic [31:0] mem [0:255];
    int          rd_wait = 0, wr_wait = 0, wait_cnt = 0, nreq = 0, nwrites = 0;
    logic [31:0] last_waddr = 32'd0, last_wdata = 32'd0;
    logic        pend_req = 1'b0, pend_we = 1'b0;
    logic [31:0] pend_addr = 32'd0, pend_wdata = 32'd0;

    initial begin
        m.mem_ready = 1'b0;
        m.mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (pend_req && m.mem_ready) begin
                if (pend_we) begin
                    mem[pend_addr[9:2]] = pend_wdata;
                    nwrites++;
                    last_waddr = pend_addr;
                    last_wdata = pend_wdata;
                end
                wait_cnt = 0;
            end
            if (m.mem_req && rst_n) begin
                nreq++;
                if (wait_cnt >= (m.mem_we ? wr_wait : rd_wait)) begin
                    m.mem_ready = 1'b1;
                    m.mem_rdata = m.mem_we ? 32'd0 : mem[m.mem_addr[9:2]];
                end else begin
                    m.mem_ready = 1'b0;
                    m.mem_rdata = 32'd0;
                    wait_cnt++;
                end
            end else begin
                m.mem_ready = 1'b0;
                m.mem_rdata = 32'd0;
                wait_cnt = 0;
            end
            pend_req   = m.mem_req;
            pend_we    = m.mem_we;
            pend_addr  = m.mem_addr;
            pend_wdata = m.mem_wdata;
        end
    end

    int n_checks = 0, n_fail = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference model
    localparam logic [4:0] LEGAL [9] = '{5'b00000, 5'b00001, 5'b00100, 5'b01000, 5'b01100,
                                        5'b10000, 5'b10100, 5'b11000, 5'b11100};

    function automatic logic model_legal(input logic [4:0] f);
        model_legal = 1'b0;
        for (int i = 0; i < 9; i++) if (LEGAL[i] == f) model_legal = 1'b1;
    endfunction

    function automatic logic [31:0] model_new(input logic [4:0] f, input logic [31:0] o, input logic [31:0] b);
        case (f)
            5'b00000: model_new = o + b;
            5'b00001: model_new = b;
            5'b00100: model_new = o ^ b;
            5'b01000: model_new = o | b;
            5'b01100: model_new = o & b;
            5'b10000: model_new = ($signed(o) < $signed(b)) ? o : b;
            5'b10100: model_new = ($signed(o) > $signed(b)) ? o : b;
            5'b11000: model_new = (o < b) ? o : b;
            default:  model_new = (o > b) ? o : b;
        endcase
    endfunction

    typedef struct {
        logic [4:0]  f;
        logic [31:0] a, init, b;
        int          rw, ww;
        logic        e, wr;
        logic [31:0] wdata, rd;
        int          lat;
    } vec_t;

    function automatic vec_t mk(input logic [4:0] f, input logic [31:0] a, input logic [31:0] init,
                                input logic [31:0] b, input int rw, input int ww, input logic e,
                                input logic wr, input logic [31:0] wdata, input logic [31:0] rd,
                                input int lat);
        vec_t v;
        v.f = f; v.a = a; v.init = init; v.b = b; v.rw = rw; v.ww = ww;
        v.e = e; v.wr = wr; v.wdata = wdata; v.rd = rd; v.lat = lat;
        return v;
    endfunction

    task automatic run_op(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                          input int rw, input int ww, output logic seen, output int lat,
                          output logic e, output logic [31:0] rd);
        rd_wait = rw;
        wr_wait = ww;
        @(negedge clk);
        funct5 = f; addr = a; rs2 = b; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0; lat = 0; e = 1'b0; rd = 32'd0;
        for (int i = 1; i <= 600; i++) begin
            if (i > 1) @(negedge clk);
            #1;
            if (done_o) begin
                seen = 1'b1; lat = i; e = err_o; rd = rd_data_o;
                break;
            end
        end
    endtask

    task automatic apply(input string tag, input vec_t v);
        logic seen, e;
        int lat, w0, r0;
        logic [31:0] rd;
        mem[v.a[9:2]] = v.init;
        w0 = nwrites;
        r0 = nreq;
        run_op(v.f, v.a, v.b, v.rw, v.ww, seen, lat, e, rd);
        check({tag, " done"}, 32'(seen), 32'd1);
        check({tag, " latency"}, lat, v.lat);
        check({tag, " err"}, 32'(e), 32'(v.e));
        check({tag, " rd_data"}, rd, v.rd);
        check({tag, " writes"}, nwrites - w0, v.wr ? 1 : 0);
        if (v.wr) begin
            check({tag, " wdata"}, last_wdata, v.wdata);
            check({tag, " waddr"}, last_waddr, {v.a[31:2], 2'b00});
        end
        if (v.e && v.lat == 1) check({tag, " no mem_req"}, nreq - r0, 0);
    endtask

    vec_t vecs[$];

    initial begin
        logic seen, e;
        int lat, w0, ndone;
        logic [31:0] rd;

        for (int i = 0; i < 256; i++) mem[i] = 32'd0;

        vecs.push_back(mk(5'b00000, 32'h100, 32'hFFFFFFFF, 32'd2, 0, 0, 0, 1, 32'h00000001, 32'hFFFFFFFF, 4));
        vecs.push_back(mk(5'b10000, 32'h104, 32'h80000000, 32'd5, 0, 0, 0, 1, 32'h80000000, 32'h80000000, 4));
        vecs.push_back(mk(5'b11000, 32'h104, 32'h80000000, 32'd5, 0, 0, 0, 1, 32'h00000005, 32'h80000000, 4));
        vecs.push_back(mk(5'b00001, 32'h108, 32'h12345678, 32'hCAFEBABE, 3, 2, 0, 1, 32'hCAFEBABE, 32'h12345678, 9));
        vecs.push_back(mk(5'b00000, 32'h102, 32'h0, 32'd1, 0, 0, 1, 0, 32'h0, 32'h0, 1));
        vecs.push_back(mk(5'b11111, 32'h100, 32'h0, 32'd1, 0, 0, 1, 0, 32'h0, 32'h0, 1));
        vecs.push_back(mk(5'b10100, 32'h10C, 32'hFFFFFFFF, 32'd1, 0, 0, 0, 1, 32'h00000001, 32'hFFFFFFFF, 4));
        vecs.push_back(mk(5'b11100, 32'h10C, 32'hFFFFFFFF, 32'd1, 0, 1, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5));
        vecs.push_back(mk(5'b00100, 32'h110, 32'hF0F0F0F0, 32'hFF00FF00, 1, 0, 0, 1, 32'h0FF00FF0, 32'hF0F0F0F0, 5));
        vecs.push_back(mk(5'b01000, 32'h110, 32'hF0F0F0F0, 32'hFF00FF00, 0, 0, 0, 1, 32'hFFF0FFF0, 32'hF0F0F0F0, 4));
        vecs.push_back(mk(5'b01100, 32'hFFFF0114, 32'hF0F0F0F0, 32'hFF00FF00, 0, 0, 0, 1, 32'hF000F000, 32'hF0F0F0F0, 4));
`ifndef AMO_LRSC_EN
        vecs.push_back(mk(5'b00010, 32'h200, 32'h0, 32'd0, 0, 0, 1, 0, 32'h0, 32'h0, 1));
        vecs.push_back(mk(5'b00011, 32'h200, 32'h0, 32'd0, 0, 0, 1, 0, 32'h0, 32'h0, 1));
`endif

        // Reset state
        #12;
        check("reset busy", 32'(busy_o), 32'd0);
        check("reset done", 32'(done_o), 32'd0);
        check("reset err", 32'(err_o), 32'd0);
        check("reset rd_data", rd_data_o, 32'd0);
        check("reset mem_req", 32'(m.mem_req), 32'd0);
        check("reset mem_addr", m.mem_addr, 32'd0);
        check("reset alu_op", 32'(alu_op_o), 32'd0);
        check("reset alu_a", alu_a_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) apply($sformatf("vec%0d", i), vecs[i]);

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            vec_t v;
            int k;
            k = $urandom_range(0, 10);
            v.f = (k < 9) ? LEGAL[k] : 5'($urandom);
            if (v.f == 5'b00010 || v.f == 5'b00011) v.f = 5'b11111;
            v.a = {$urandom} & ~32'h3;
            if (k == 10) v.a[1:0] = 2'($urandom_range(1, 3));
            v.init = $urandom;
            v.b = $urandom;
            v.rw = $urandom_range(0, 3);
            v.ww = $urandom_range(0, 3);
            v.e = !model_legal(v.f) || (v.a[1:0] != 2'b00);
            v.wr = !v.e;
            v.wdata = model_new(v.f, v.init, v.b);
            v.rd = v.e ? 32'd0 : v.init;
            v.lat = v.e ? 1 : 4 + v.rw + v.ww;
            apply($sformatf("rand%0d", i), v);
        end

        // Read timeout
        w0 = nwrites;
        run_op(5'b00000, 32'h20, 32'd1, 100000, 0, seen, lat, e, rd);
        check("rd timeout latency", lat, TO + 1);
        check("rd timeout err", 32'(e), 32'd1);
        check("rd timeout rd_data", rd, 32'd0);
        check("rd timeout mem_req", 32'(m.mem_req), 32'd0);
        check("rd timeout writes", nwrites - w0, 0);

        // Write timeout
        w0 = nwrites;
        run_op(5'b00000, 32'h24, 32'd1, 0, 100000, seen, lat, e, rd);
        check("wr timeout latency", lat, TO + 3);
        check("wr timeout err", 32'(e), 32'd1);
        check("wr timeout rd_data", rd, 32'd0);
        check("wr timeout writes", nwrites - w0, 0);

        // Start while busy is ignored
        w0 = nwrites;
        rd_wait = 3; wr_wait = 0;
        @(negedge clk);
        funct5 = 5'b00000; addr = 32'h40; rs2 = 32'd7; start = 1'b1;
        mem[8'h10] = 32'd10;
        @(negedge clk);
        funct5 = 5'b00001; addr = 32'h44; start = 1'b1;
        #1;
        check("busy during op", 32'(busy_o), 32'd1);
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (done_o) ndone++;
            @(negedge clk);
        end
        check("busy start ignored dones", ndone, 1);
        check("busy start ignored writes", nwrites - w0, 1);
        check("busy start wdata", last_wdata, 32'd17);

        // Asynchronous reset during WR
        w0 = nwrites;
        rd_wait = 0; wr_wait = 100000;
        @(negedge clk);
        funct5 = 5'b00000; addr = 32'h48; rs2 = 32'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (m.mem_req && m.mem_we) seen = 1'b1;
        end
        check("reached WR", 32'(seen), 32'd1);
        rst_n = 1'b0;
        #1;
        check("reset drops mem_req", 32'(m.mem_req), 32'd0);
        ndone = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            if (done_o) ndone++;
        end
        check("reset no done", ndone, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wr_wait = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            if (done_o) ndone++;
        end
        check("reset no done after release", ndone, 0);
        check("reset no write", nwrites - w0, 0);

`ifdef AMO_LRSC_EN
        mem[8'h80] = 32'hAAAA5555;
        w0 = nwrites;
        run_op(5'b00010, 32'h200, 32'd0, 0, 0, seen, lat, e, rd);
        check("lr rd_data", rd, 32'hAAAA5555);
        check("lr err", 32'(e), 32'd0);
        check("lr writes", nwrites - w0, 0);
        run_op(5'b00011, 32'h200, 32'h13579BDF, 0, 0, seen, lat, e, rd);
        check("sc1 rd_data", rd, 32'd0);
        check("sc1 writes", nwrites - w0, 1);
        check("sc1 wdata", last_wdata, 32'h13579BDF);
        run_op(5'b00011, 32'h200, 32'h2468ACE0, 0, 0, seen, lat, e, rd);
        check("sc2 rd_data", rd, 32'd1);
        check("sc2 writes", nwrites - w0, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
